instr_exec_unit: RTL and testbench



---
 rtl/instr_exec_unit.sv | 189 ++++++++++++++++++
 tb/tb_instr_exec_unit.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_exec_unit.sv
// Execution stage: takes one instruction word plus its register tag, runs it
// through a single-cycle ALU/multiplier or a 32-step restoring divider, and
// hands {opcode, tag, result} downstream over a valid/ready handshake.
module instr_exec_unit #(
    parameter int OP_W  = 32,
    parameter int RES_W = 64,
    parameter int TAG_W = 5,
    parameter int CNT_W = 16
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [2:0]              in_opc,
    input  logic signed [OP_W-1:0]  in_op_a,
    input  logic signed [OP_W-1:0]  in_op_b,
    input  logic [TAG_W-1:0]        in_tag,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [2:0]              out_opc,
    output logic [TAG_W-1:0]        out_tag,
    output logic signed [RES_W-1:0] out_result,
    output logic                    busy,
    output logic [CNT_W-1:0]        ops_done
);

    localparam logic [2:0] OPC_ZERO  = 3'd0;
    localparam logic [2:0] OPC_PASSA = 3'd1;
    localparam logic [2:0] OPC_PASSB = 3'd2;
    localparam logic [2:0] OPC_ADD   = 3'd3;
    localparam logic [2:0] OPC_SUB   = 3'd4;
    localparam logic [2:0] OPC_MULT  = 3'd5;
    localparam logic [2:0] OPC_DIV   = 3'd6;
    localparam logic [2:0] OPC_MOD   = 3'd7;

    localparam logic [5:0] LAST_STEP = 6'(OP_W - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_nxt;

    // Magnitude of a two's-complement operand; -2^(OP_W-1) maps to
    // 2^(OP_W-1), which still fits an unsigned OP_W-bit value.
    function automatic logic [OP_W-1:0] abs_mag(input logic signed [OP_W-1:0] v);
        logic [OP_W-1:0] u;
        u = v;
        return v[OP_W-1] ? (~u + OP_W'(1)) : u;
    endfunction

    // Zero-extend an unsigned magnitude to RES_W and optionally negate it.
    function automatic logic signed [RES_W-1:0] apply_sign(input logic [OP_W-1:0] mag,
                                                            input logic neg);
        logic signed [RES_W-1:0] ext;
        ext = {{(RES_W-OP_W){1'b0}}, mag};
        return neg ? -ext : ext;
    endfunction

    logic                    accept;
    logic                    is_divmod;
    logic                    div_by_zero;
    logic signed [RES_W-1:0] a_ext;
    logic signed [RES_W-1:0] b_ext;
    logic signed [RES_W-1:0] single_res;

    // Divider state: quo shifts the dividend out while quotient bits shift in.
    logic [OP_W-1:0]         quo;
    logic [OP_W-1:0]         rem;
    logic [OP_W-1:0]         dvs;
    logic [5:0]              step;
    logic                    neg_q;
    logic                    neg_r;

    logic [OP_W:0]           rem_sh;
    logic                    sub_ok;
    logic [OP_W-1:0]         rem_nxt;
    logic [OP_W-1:0]         quo_nxt;
    logic signed [RES_W-1:0] div_res;

    assign in_ready    = (state == IDLE);
    assign out_valid   = (state == DONE);
    assign busy        = (state == CALC);
    assign accept      = in_valid && in_ready;
    assign is_divmod   = (in_opc == OPC_DIV) || (in_opc == OPC_MOD);
    assign div_by_zero = (in_op_b == '0);

    // Single-cycle result computed straight from the input bus at accept.
    always_comb begin
        a_ext      = {{(RES_W-OP_W){in_op_a[OP_W-1]}}, in_op_a};
        b_ext      = {{(RES_W-OP_W){in_op_b[OP_W-1]}}, in_op_b};
        single_res = '0;
        case (in_opc)
            OPC_ZERO:  single_res = '0;
            OPC_PASSA: single_res = a_ext;
            OPC_PASSB: single_res = b_ext;
            OPC_ADD:   single_res = a_ext + b_ext;
            OPC_SUB:   single_res = a_ext - b_ext;
            OPC_MULT:  single_res = a_ext * b_ext;
            default:   single_res = '0;
        endcase
    end

    // One restoring-division step plus the sign fix-up of its outcome.
    always_comb begin
        rem_sh  = {rem, quo[OP_W-1]};
        sub_ok  = (rem_sh >= {1'b0, dvs});
        rem_nxt = sub_ok ? OP_W'(rem_sh - {1'b0, dvs}) : rem_sh[OP_W-1:0];
        quo_nxt = {quo[OP_W-2:0], sub_ok};
        div_res = (out_opc == OPC_MOD) ? apply_sign(rem_nxt, neg_r)
                                       : apply_sign(quo_nxt, neg_q);
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: divides with a nonzero divisor detour through CALC.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    state_nxt = (is_divmod && !div_by_zero) ? CALC : DONE;
                end
            end
            CALC: begin
                if (step == LAST_STEP) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Capture the instruction on accept and iterate the divider in CALC.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_opc    <= '0;
            out_tag    <= '0;
            out_result <= '0;
            quo        <= '0;
            rem        <= '0;
            dvs        <= '0;
            step       <= '0;
            neg_q      <= 1'b0;
            neg_r      <= 1'b0;
        end else if (accept) begin
            out_opc    <= in_opc;
            out_tag    <= in_tag;
            out_result <= single_res;
            quo        <= abs_mag(in_op_a);
            rem        <= '0;
            dvs        <= abs_mag(in_op_b);
            step       <= '0;
            neg_q      <= in_op_a[OP_W-1] ^ in_op_b[OP_W-1];
            neg_r      <= in_op_a[OP_W-1];
        end else if (state == CALC) begin
            quo  <= quo_nxt;
            rem  <= rem_nxt;
            step <= step + 6'd1;
            if (step == LAST_STEP) begin
                out_result <= div_res;
            end
        end
    end

    // Count completed handoffs; wraps naturally.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ops_done <= '0;
        end else if (out_valid && out_ready) begin
            ops_done <= ops_done + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_instr_exec_unit.sv
// Directed bench for instr_exec_unit with a queue-based scoreboard.
module tb_instr_exec_unit;

    logic               clk;
    logic               reset_n;
    logic               in_valid;
    logic               in_ready;
    logic [2:0]         in_opc;
    logic signed [31:0] in_op_a;
    logic signed [31:0] in_op_b;
    logic [4:0]         in_tag;
    logic               out_valid;
    logic               out_ready;
    logic [2:0]         out_opc;
    logic [4:0]         out_tag;
    logic signed [63:0] out_result;
    logic               busy;
    logic [15:0]        ops_done;

    instr_exec_unit #(.OP_W(32), .RES_W(64), .TAG_W(5), .CNT_W(16)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_opc     (in_opc),
        .in_op_a    (in_op_a),
        .in_op_b    (in_op_b),
        .in_tag     (in_tag),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_opc    (out_opc),
        .out_tag    (out_tag),
        .out_result (out_result),
        .busy       (busy),
        .ops_done   (ops_done)
    );

    typedef struct {
        logic [2:0]         opc;
        logic [4:0]         tag;
        logic signed [63:0] res;
        int                 lat;
        int                 busy_cyc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   n_done = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic logic signed [63:0] model(input logic [2:0] opc,
                                                 input logic signed [31:0] a,
                                                 input logic signed [31:0] b);
        logic signed [63:0] a64;
        logic signed [63:0] b64;
        a64 = 64'(a);
        b64 = 64'(b);
        case (opc)
            3'd0: return 64'sd0;
            3'd1: return a64;
            3'd2: return b64;
            3'd3: return a64 + b64;
            3'd4: return a64 - b64;
            3'd5: return a64 * b64;
            3'd6: return (b == 0) ? 64'sd0 : a64 / b64;
            default: return (b == 0) ? 64'sd0 : a64 % b64;
        endcase
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)",
                   tag, $signed(obs), obs, $signed(exp), exp);
        end
    endtask

    // Present one instruction (called just after a falling edge), wait for it
    // to be accepted, log the expectation and return at the next falling edge.
    task automatic send(input logic [2:0] opc, input logic signed [31:0] a,
                        input logic signed [31:0] b, input logic [4:0] tag);
        exp_t e;
        int   waited;
        in_valid = 1'b1;
        in_opc   = opc;
        in_op_a  = a;
        in_op_b  = b;
        in_tag   = tag;
        waited   = 0;
        while (!in_ready && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) check("accept_timeout", 64'(in_ready), 64'd1);
        @(posedge clk);
        e.opc      = opc;
        e.tag      = tag;
        e.res      = model(opc, a, b);
        e.lat      = (opc >= 3'd6 && b != 0) ? 33 : 1;
        e.busy_cyc = (opc >= 3'd6 && b != 0) ? 32 : 0;
        sb.push_back(e);
        @(negedge clk);
        in_valid = 1'b0;
        in_opc   = 3'd0;
        in_op_a  = 32'sd0;
        in_op_b  = 32'sd0;
        in_tag   = 5'd0;
    endtask

    // Wait (bounded) for out_valid, then compare against the oldest expectation.
    task automatic wait_out(input string name);
        exp_t e;
        int   lat;
        int   busy_cnt;
        lat      = 1;
        busy_cnt = 0;
        while (!out_valid && lat < 200) begin
            if (busy) busy_cnt++;
            @(negedge clk);
            lat++;
        end
        check({name, "_out_valid"}, 64'(out_valid), 64'd1);
        check({name, "_sb_size"}, 64'(sb.size()), 64'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check({name, "_latency"}, 64'(lat), 64'(e.lat));
            check({name, "_busy_cycles"}, 64'(busy_cnt), 64'(e.busy_cyc));
            check({name, "_opc"}, 64'(out_opc), 64'(e.opc));
            check({name, "_tag"}, 64'(out_tag), 64'(e.tag));
            check({name, "_result"}, out_result, e.res);
        end
    endtask

    // With out_ready high, the handoff happens at the next rising edge.
    task automatic after_handoff(input string name);
        @(negedge clk);
        n_done++;
        check({name, "_valid_dropped"}, 64'(out_valid), 64'd0);
        check({name, "_in_ready"}, 64'(in_ready), 64'd1);
        check({name, "_ops_done"}, 64'(ops_done), 64'(n_done));
    endtask

    task automatic run_op(input string name, input logic [2:0] opc,
                          input logic signed [31:0] a, input logic signed [31:0] b,
                          input logic [4:0] tag);
        send(opc, a, b, tag);
        wait_out(name);
        after_handoff(name);
    endtask

    initial begin
        logic [2:0]         r_opc;
        logic signed [31:0] r_a;
        logic signed [31:0] r_b;

        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_opc    = 3'd0;
        in_op_a   = 32'sd0;
        in_op_b   = 32'sd0;
        in_tag    = 5'd0;
        out_ready = 1'b1;

        repeat (3) @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_ops_done", 64'(ops_done), 64'd0);
        check("rst_out_result", out_result, 64'd0);
        check("rst_out_tag", 64'(out_tag), 64'd0);
        check("rst_out_opc", 64'(out_opc), 64'd0);
        reset_n = 1'b1;
        @(negedge clk);

        run_op("add", 3'd3, -32'sd15, 32'sd7, 5'd3);
        run_op("mult", 3'd5, -32'sd15, 32'sd15, 5'd4);
        run_op("sub", 3'd4, 32'sd5, 32'sd12, 5'd5);
        run_op("zero", 3'd0, 32'sd123, -32'sd9, 5'd6);
        run_op("passb", 3'd2, 32'sd1, -32'sd77, 5'd7);

        run_op("div_neg", 3'd6, -32'sd15, 32'sd4, 5'd8);
        run_op("mod_neg", 3'd7, -32'sd15, 32'sd4, 5'd9);
        run_op("mod_pos", 3'd7, 32'sd15, -32'sd4, 5'd10);
        run_op("div_by_zero", 3'd6, 32'sd9, 32'sd0, 5'd11);
        run_op("mod_by_zero", 3'd7, 32'sd9, 32'sd0, 5'd12);

        run_op("div_min_m1", 3'd6, 32'sh8000_0000, -32'sd1, 5'd13);
        run_op("mod_min_m1", 3'd7, 32'sh8000_0000, -32'sd1, 5'd14);
        run_op("div_min_min", 3'd6, 32'sh8000_0000, 32'sh8000_0000, 5'd15);
        run_op("mod_small_min", 3'd7, 32'sd7, 32'sh8000_0000, 5'd16);
        run_op("div_max_3", 3'd6, 32'sh7fff_ffff, 32'sd3, 5'd17);
        run_op("mult_min_min", 3'd5, 32'sh8000_0000, 32'sh8000_0000, 5'd18);

        // Backpressure: result must hold while the consumer stalls.
        out_ready = 1'b0;
        send(3'd1, -32'sd1, 32'sd0, 5'd21);
        wait_out("bp");
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_hold_valid", 64'(out_valid), 64'd1);
            check("bp_hold_result", out_result, -64'sd1);
            check("bp_hold_tag", 64'(out_tag), 64'd21);
            check("bp_hold_in_ready", 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        after_handoff("bp");

        // Reset in the middle of a divide discards it.
        send(3'd6, -32'sd1000, 32'sd7, 5'd9);
        repeat (9) @(negedge clk);
        check("mid_div_busy", 64'(busy), 64'd1);
        #2 reset_n = 1'b0;
        #1;
        check("rst_mid_out_valid", 64'(out_valid), 64'd0);
        check("rst_mid_ops_done", 64'(ops_done), 64'd0);
        check("rst_mid_busy", 64'(busy), 64'd0);
        sb.delete();
        n_done = 0;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("post_rst_in_ready", 64'(in_ready), 64'd1);
        check("post_rst_out_valid", 64'(out_valid), 64'd0);
        run_op("passb_after_rst", 3'd2, 32'sd0, 32'sd6, 5'd2);

        // A handful of pseudo-random instructions across all opcodes.
        for (int i = 0; i < 12; i++) begin
            r_opc = 3'($urandom_range(0, 7));
            r_a   = $urandom;
            r_b   = (i % 4 == 1) ? 32'($urandom_range(1, 9)) : $urandom;
            if (i % 3 == 2) r_a = r_a >>> 12;
            run_op("rand", r_opc, r_a, r_b, 5'(i));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
